enc_binder_seq: RTL and testbench
=================================

Name: enc_binder_seq

Overview:
- Time-multiplexed, parametrised successor to the fixed per-feature binder pack.
- Accepts a batch of FEATURES level hypervectors and binds each one by circular rotation, using a per-feature shift taken from the shared SHIFTS table at a runtime base offset.
- Only LANES physical rotators are instantiated; results stream out over ceil(FEATURES/LANES) beats under a valid/ready handshake.
- Sits between the level-HV lookup and the bundler in the encoder.

Parameters:
- HV_DIM, 1024, hypervector width in bits.
- FEATURES, 8, feature HVs per batch; must be >= 1.
- LANES, 2, rotators and output lanes per beat; 1 <= LANES <= FEATURES.
- IDX_W, 16, width of shift_base and out_feat_idx.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- start_encoding  in  1  batch valid; accepted when in_ready=1.
- in_ready  out  1  high only in IDLE.
- level_hv  in  HV_DIM x [0:FEATURES-1]  batch input; sampled on accept only.
- shift_base  in  IDX_W  SHIFTS table base index; sampled on accept.
- mode  in  2  00 ROTL, 01 ROTR, 10 BYPASS, 11 reserved (treated as BYPASS); sampled on accept.
- shifted_hv  out  HV_DIM x [0:LANES-1]  bound HVs for the current beat.
- lane_valid  out  LANES  per-lane valid within the beat.
- out_feat_idx  out  IDX_W  feature index of lane 0 in the current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of the batch.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (nrst=0 at a clk edge):
  - state=IDLE.
  - All outputs zero except in_ready=1; internal registers cleared.
  - Applies mid-batch too: the batch is abandoned, no done pulse.
- States: IDLE, BIND.
- IDLE -> BIND on start_encoding && in_ready:
  - Capture level_hv, shift_base and mode.
  - beat=0.
- BIND:
  - out_valid=1 from the cycle after accept, so first-beat latency is 1 clk.
  - Lane j of beat b handles feature k = b*LANES + j.
  - Shift s_k = SHIFTS[(shift_base + k) mod SHIFT_TABLE_LEN] mod HV_DIM.
  - ROTL: shifted_hv[j] = level_hv[k] rotated left by s_k.
  - ROTR: shifted_hv[j] = level_hv[k] rotated left by (HV_DIM - s_k) mod HV_DIM.
  - BYPASS: shifted_hv[j] = level_hv[k].
  - Beat outputs are registered, and the rotation is computed for the next beat.
- Stall: while out_valid && !out_ready, all beat outputs hold stable.
- Advance: on out_valid && out_ready:
  - If not the last beat: beat++ and the next beat is presented the following cycle, so there are no bubbles under continuous out_ready.
  - If the last beat: state -> IDLE and done=1 for exactly that next cycle; out_valid=0.
- Last beat:
  - out_last=1 when b = ceil(FEATURES/LANES)-1.
  - Lanes with k >= FEATURES have lane_valid=0 and shifted_hv=0.
- out_feat_idx = b*LANES.
- start_encoding while in BIND is ignored; in_ready=0.
- Minimum gap between batches is 1 IDLE cycle. The next accept can coincide with the done cycle.
- The captured batch is immune to level_hv changes after accept.

Decomposition:
- Package hdc_pkg holds:
  - HV_DIM default.
  - SHIFTS table and SHIFT_TABLE_LEN.
  - mode_e enum (ROTL, ROTR, BYPASS).
  - Helper function for the shift index wrap.
- Sub-module hdc_rotl:
  - Combinational barrel rotate-left, HV_DIM bits, $clog2(HV_DIM)-bit amount.
  - LANES instances.
  - Shares the rotation semantics of the existing single-feature binder.

Test Plan:
- Reset/idle: nrst=0 for 2 cycles, then 1 -> in_ready=1, out_valid=0, done=0, shifted_hv all 0.
- Basic ROTL (FEATURES=8, LANES=2, shift_base=248):
  - Stimulus: level_hv[k] = 1<<k, out_ready=1.
  - Expect 4 consecutive beats starting 1 cycle after accept.
  - Beat 1 lane 1 = rotl(1<<3, SHIFTS[251]); out_feat_idx = 0, 2, 4, 6.
  - out_last on beat 3 only; done the cycle after.
- ROTR/BYPASS round trip:
  - ROTR on a random HV, then ROTL applied to the output with the same base -> original HV.
  - BYPASS returns the inputs unchanged for all 8 features.
- Backpressure: hold out_ready=0 for 5 cycles on beat 2 -> outputs stable, then beats 2 and 3 follow; no beat lost or duplicated.
- Partial last beat (FEATURES=5, LANES=2):
  - 3 beats; beat 2 has lane_valid=2'b01 and lane 1 = 0.
  - shift_base = SHIFT_TABLE_LEN-1 checks index wrap: feature 1 uses SHIFTS[0].
- Mid-batch reset and ignored start:
  - start_encoding pulsed during beat 1 -> ignored.
  - nrst=0 during beat 2 -> next cycle state is IDLE, out_valid=0, no done pulse.
  - A new batch then runs cleanly.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg
//   Shared definitions for the hypervector encoder datapath:
//     - HV_DIM_DEF      : default hypervector width in bits
//     - SHIFTS table    : per-index binding shift, exposed through shifts_at()
//     - SHIFT_TABLE_LEN : number of entries in the SHIFTS table
//     - mode_e          : binding operation selector
//     - state_e         : sequencer state encoding
//     - wrap_shift_idx(): base+feature index wrapped into the table
package hdc_pkg;

  localparam int HV_DIM_DEF      = 1024;
  localparam int SHIFT_TABLE_LEN = 256;
  localparam int SHIFT_W         = 16;

  // Table contents: SHIFTS[i] = (389*i + 7) mod 2048. Entries may exceed
  // HV_DIM on purpose; users reduce them modulo their own HV_DIM.
  localparam int unsigned SHIFT_MUL = 389;
  localparam int unsigned SHIFT_ADD = 7;
  localparam int unsigned SHIFT_MOD = 2048;

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BYPASS = 2'b10
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BIND = 1'b1
  } state_e;

  // Read one entry of the SHIFTS table. idx must already be < SHIFT_TABLE_LEN.
  function automatic logic [SHIFT_W-1:0] shifts_at(input int unsigned idx);
    return SHIFT_W'((idx * SHIFT_MUL + SHIFT_ADD) % SHIFT_MOD);
  endfunction

  // Table index used by feature k of a batch started at base.
  function automatic int unsigned wrap_shift_idx(input int unsigned base,
                                                 input int unsigned k);
    return (base + k) % SHIFT_TABLE_LEN;
  endfunction

endpackage

// File: rtl/hdc_rotl.sv
// hdc_rotl
//   Combinational barrel rotate-left of one hypervector.
//   Ports:
//     i_hv  [HV_DIM-1:0] : hypervector to rotate
//     i_amt [AMT_W-1:0]  : rotate-left amount, expected < HV_DIM
//     o_hv  [HV_DIM-1:0] : i_hv rotated left by i_amt
module hdc_rotl
  import hdc_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEF,
  parameter int AMT_W  = $clog2(HV_DIM)
) (
  input  logic [HV_DIM-1:0] i_hv,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [HV_DIM-1:0] o_hv
);

  logic [HV_DIM-1:0] w_acc;

  // log2 stages, stage i rotates by 2**i. Every stage step is < HV_DIM, so
  // the composition equals rotation by i_amt mod HV_DIM even when HV_DIM is
  // not a power of two.
  always_comb begin
    w_acc = i_hv;
    for (int i = 0; i < AMT_W; i++) begin
      if (i_amt[i]) begin
        w_acc = (w_acc << (1 << i)) | (w_acc >> (HV_DIM - (1 << i)));
      end
    end
    o_hv = w_acc;
  end

endmodule

// File: rtl/enc_binder_seq.sv
// enc_binder_seq
//   Time-multiplexed feature binder. A batch of FEATURES level hypervectors is
//   captured on accept and each is rotated by its SHIFTS-table amount; LANES
//   rotators stream the results out over ceil(FEATURES/LANES) beats.
//   Ports:
//     clk, nrst          : clock, synchronous active-low reset
//     start_encoding     : batch valid, accepted while in_ready=1
//     in_ready           : high only in IDLE
//     level_hv[FEATURES] : batch hypervectors, sampled on accept
//     shift_base         : SHIFTS table base index, sampled on accept
//     mode               : 00 ROTL, 01 ROTR, 10/11 BYPASS, sampled on accept
//     shifted_hv[LANES]  : bound hypervectors of the current beat
//     lane_valid         : per-lane valid within the beat
//     out_feat_idx       : feature index carried by lane 0
//     out_valid/out_ready: beat handshake
//     out_last           : final beat of the batch
//     done               : one-cycle pulse after the final beat is taken
//     o_dbg_state        : current sequencer state
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready are both
// high at the rising edge. While out_valid is high and out_ready is low every
// beat output holds its value. out_valid never drops before its beat
// transfers (except on reset). Input side: a batch is taken on a cycle where
// start_encoding && in_ready are high at the rising edge.
module enc_binder_seq
  import hdc_pkg::*;
#(
  parameter int HV_DIM   = HV_DIM_DEF,
  parameter int FEATURES = 8,
  parameter int LANES    = 2,
  parameter int IDX_W    = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] level_hv [0:FEATURES-1],
  input  logic [IDX_W-1:0]  shift_base,
  input  logic [1:0]        mode,
  output logic [HV_DIM-1:0] shifted_hv [0:LANES-1],
  output logic [LANES-1:0]  lane_valid,
  output logic [IDX_W-1:0]  out_feat_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output state_e            o_dbg_state
);

  localparam int NUM_BEATS = (FEATURES + LANES - 1) / LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int FIDX_W    = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int AMT_W     = $clog2(HV_DIM);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  // Registered state and captured batch
  state_e             r_state;
  logic [HV_DIM-1:0]  r_hv [0:FEATURES-1];
  logic [IDX_W-1:0]   r_base;
  logic [1:0]         r_mode;
  logic [BEAT_W-1:0]  r_beat;

  // Registered beat outputs
  logic [HV_DIM-1:0]  r_shifted [0:LANES-1];
  logic [LANES-1:0]   r_lane_valid;
  logic [IDX_W-1:0]   r_feat_idx;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_done;

  // Control
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_advance;
  logic               w_finish;
  logic [BEAT_W-1:0]  w_calc_beat;
  logic [IDX_W-1:0]   w_src_base;
  logic [1:0]         w_src_mode;

  // Per-lane results for the beat being prepared
  logic [HV_DIM-1:0]  w_lane_hv [0:LANES-1];
  logic [LANES-1:0]   w_lane_ok;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_encoding) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BIND;
        end
      end
      S_BIND: begin
        if (r_out_valid && out_ready) begin
          if (r_beat == LAST_BEAT) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The rotators always work one beat ahead of the registered outputs. On
  // accept the captured registers are not loaded yet, so beat 0 is built
  // straight from the input ports; afterwards from the captured copy.
  always_comb begin
    w_calc_beat = w_accept ? '0 : r_beat + 1'b1;
    w_src_base  = w_accept ? shift_base : r_base;
    w_src_mode  = w_accept ? mode : r_mode;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [31:0]       w_k;
    logic              w_ok;
    logic [FIDX_W-1:0] w_sel;
    logic [31:0]       w_s;
    logic [AMT_W-1:0]  w_amt;
    logic [HV_DIM-1:0] w_in;
    logic [HV_DIM-1:0] w_rot;

    always_comb begin
      w_k   = 32'(w_calc_beat) * 32'(LANES) + 32'(j);
      w_ok  = (w_k < 32'(FEATURES));
      // Lanes past the end of the batch read feature 0; their result is
      // forced to zero below.
      w_sel = w_ok ? FIDX_W'(w_k) : '0;
      w_in  = w_accept ? level_hv[w_sel] : r_hv[w_sel];
      w_s   = 32'(shifts_at(wrap_shift_idx(32'(w_src_base), w_k))) % 32'(HV_DIM);
      // ROTR is a left rotation by the complement; BYPASS and the reserved
      // code rotate by zero.
      case (w_src_mode)
        MODE_ROTL: w_amt = AMT_W'(w_s);
        MODE_ROTR: w_amt = AMT_W'((32'(HV_DIM) - w_s) % 32'(HV_DIM));
        default:   w_amt = '0;
      endcase
    end

    hdc_rotl #(
      .HV_DIM (HV_DIM),
      .AMT_W  (AMT_W)
    ) u_rotl (
      .i_hv  (w_in),
      .i_amt (w_amt),
      .o_hv  (w_rot)
    );

    assign w_lane_hv[j] = w_ok ? w_rot : '0;
    assign w_lane_ok[j] = w_ok;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_mode       <= '0;
      r_beat       <= '0;
      r_lane_valid <= '0;
      r_feat_idx   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_done       <= 1'b0;
      for (int f = 0; f < FEATURES; f++) r_hv[f] <= '0;
      for (int j = 0; j < LANES; j++) r_shifted[j] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;
      if (w_accept) begin
        r_hv   <= level_hv;
        r_base <= shift_base;
        r_mode <= mode;
      end
      if (w_accept || w_advance) begin
        r_beat       <= w_calc_beat;
        r_out_valid  <= 1'b1;
        r_out_last   <= (w_calc_beat == LAST_BEAT);
        r_lane_valid <= w_lane_ok;
        r_feat_idx   <= IDX_W'(32'(w_calc_beat) * 32'(LANES));
        r_shifted    <= w_lane_hv;
      end else if (w_finish) begin
        r_beat       <= '0;
        r_out_valid  <= 1'b0;
        r_out_last   <= 1'b0;
        r_lane_valid <= '0;
        r_feat_idx   <= '0;
        for (int j = 0; j < LANES; j++) r_shifted[j] <= '0;
      end
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign shifted_hv   = r_shifted;
  assign lane_valid   = r_lane_valid;
  assign out_feat_idx = r_feat_idx;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_enc_binder_seq.sv
// tb_enc_binder_seq
//   Directed bench for enc_binder_seq with two instances: FEATURES=8/LANES=2
//   and FEATURES=5/LANES=2 (partial last beat). Expected bit positions were
//   worked out by hand from SHIFTS[i] = (389*i + 7) mod 2048.
module tb_enc_binder_seq;
  import hdc_pkg::*;

  localparam int D = 1024;

  // Clock / reset
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // Instance with 8 features
  logic          start8, in_ready8, ov8, ordy8, last8, done8;
  logic [D-1:0]  lv8 [0:7];
  logic [D-1:0]  sh8 [0:1];
  logic [15:0]   base8, idx8;
  logic [1:0]    mode8, lval8;
  state_e        st8;

  // Instance with 5 features
  logic          start5, in_ready5, ov5, ordy5, last5, done5;
  logic [D-1:0]  lv5 [0:4];
  logic [D-1:0]  sh5 [0:1];
  logic [15:0]   base5, idx5;
  logic [1:0]    mode5, lval5;
  state_e        st5;

  enc_binder_seq #(.HV_DIM(D), .FEATURES(8), .LANES(2), .IDX_W(16)) dut8 (
    .clk(clk), .nrst(nrst), .start_encoding(start8), .in_ready(in_ready8),
    .level_hv(lv8), .shift_base(base8), .mode(mode8), .shifted_hv(sh8),
    .lane_valid(lval8), .out_feat_idx(idx8), .out_valid(ov8), .out_ready(ordy8),
    .out_last(last8), .done(done8), .o_dbg_state(st8)
  );

  enc_binder_seq #(.HV_DIM(D), .FEATURES(5), .LANES(2), .IDX_W(16)) dut5 (
    .clk(clk), .nrst(nrst), .start_encoding(start5), .in_ready(in_ready5),
    .level_hv(lv5), .shift_base(base5), .mode(mode5), .shifted_hv(sh5),
    .lane_valid(lval5), .out_feat_idx(idx5), .out_valid(ov5), .out_ready(ordy5),
    .out_last(last5), .done(done5), .o_dbg_state(st5)
  );

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [D-1:0] exp8 [0:7];
  logic [D-1:0] got8 [0:7];
  logic [D-1:0] orig [0:7];
  logic [D-1:0] exp5 [0:5];

  // Hand-computed destination bit of input bit k, base 248
  int rotl_pos [0:7] = '{223, 613, 1003, 369, 759, 125, 515, 905};
  int rotr_pos [0:7] = '{801, 413, 25, 661, 273, 909, 521, 133};
  // FEATURES=5, base 255 (wraps to SHIFTS[0] at feature 1)
  int part_pos [0:4] = '{898, 8, 398, 788, 154};

  function automatic logic [D-1:0] oh(input int p);
    logic [D-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [D-1:0] rnd_hv();
    logic [D-1:0] v;
    for (int i = 0; i < D / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_hv(input string tag, input logic [D-1:0] obs, input logic [D-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed[127:0]=%h expected[127:0]=%h", tag, obs[127:0], expv[127:0]);
    end
  endtask

  task automatic check_beat8(input string tag, input int b, input bit use_exp);
    chk($sformatf("%s b%0d out_valid", tag, b), 32'(ov8), 32'd1);
    chk($sformatf("%s b%0d feat_idx", tag, b), 32'(idx8), 32'(b * 2));
    chk($sformatf("%s b%0d out_last", tag, b), 32'(last8), (b == 3) ? 32'd1 : 32'd0);
    chk($sformatf("%s b%0d lane_valid", tag, b), 32'(lval8), 32'd3);
    if (use_exp) begin
      chk_hv($sformatf("%s b%0d lane0", tag, b), sh8[0], exp8[2*b]);
      chk_hv($sformatf("%s b%0d lane1", tag, b), sh8[1], exp8[2*b+1]);
    end
  endtask

  // Runs one 8-feature batch from the current lv8 and collects every lane
  // into got8. Optionally stalls on one beat for stall_len cycles.
  task automatic run_batch8(input logic [15:0] base, input logic [1:0] md,
                            input int stall_beat, input int stall_len,
                            input bit use_exp, input string tag);
    chk({tag, " in_ready"}, 32'(in_ready8), 32'd1);
    start8 = 1'b1; base8 = base; mode8 = md; ordy8 = 1'b1;
    tick();
    start8 = 1'b0; base8 = 16'd0; mode8 = 2'b00;
    for (int k = 0; k < 8; k++) lv8[k] = ~lv8[k];  // batch must already be captured
    chk({tag, " busy"}, 32'(in_ready8), 32'd0);
    for (int b = 0; b < 4; b++) begin
      check_beat8(tag, b, use_exp);
      if (b == stall_beat) begin
        ordy8 = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check_beat8({tag, " stall"}, b, use_exp);
        end
        ordy8 = 1'b1;
      end
      got8[2*b]   = sh8[0];
      got8[2*b+1] = sh8[1];
      tick();
    end
    chk({tag, " done"}, 32'(done8), 32'd1);
    chk({tag, " idle valid"}, 32'(ov8), 32'd0);
    chk({tag, " idle ready"}, 32'(in_ready8), 32'd1);
    tick();
    chk({tag, " done clr"}, 32'(done8), 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    start8 = 1'b0; base8 = '0; mode8 = '0; ordy8 = 1'b0;
    start5 = 1'b0; base5 = '0; mode5 = '0; ordy5 = 1'b0;
    for (int k = 0; k < 8; k++) lv8[k] = '0;
    for (int k = 0; k < 5; k++) lv5[k] = '0;

    // Reset / idle
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    chk("rst in_ready", 32'(in_ready8), 32'd1);
    chk("rst out_valid", 32'(ov8), 32'd0);
    chk("rst done", 32'(done8), 32'd0);
    chk("rst out_last", 32'(last8), 32'd0);
    chk("rst lane_valid", 32'(lval8), 32'd0);
    chk("rst state", 32'(st8), 32'(S_IDLE));
    chk_hv("rst lane0", sh8[0], '0);
    chk_hv("rst lane1", sh8[1], '0);
    chk("rst5 in_ready", 32'(in_ready5), 32'd1);

    // Basic ROTL on one-hot inputs
    for (int k = 0; k < 8; k++) begin lv8[k] = oh(k); exp8[k] = oh(rotl_pos[k]); end
    run_batch8(16'd248, 2'b00, -1, 0, 1'b1, "rotl");

    // ROTR on one-hot inputs with 5-cycle backpressure on beat 2
    for (int k = 0; k < 8; k++) begin lv8[k] = oh(k); exp8[k] = oh(rotr_pos[k]); end
    run_batch8(16'd248, 2'b01, 2, 5, 1'b1, "rotr");

    // ROTR then ROTL with the same base restores a random batch
    for (int k = 0; k < 8; k++) begin orig[k] = rnd_hv(); lv8[k] = orig[k]; end
    run_batch8(16'd100, 2'b01, -1, 0, 1'b0, "rt fwd");
    for (int k = 0; k < 8; k++) lv8[k] = got8[k];
    run_batch8(16'd100, 2'b00, -1, 0, 1'b0, "rt back");
    for (int k = 0; k < 8; k++) chk_hv($sformatf("roundtrip f%0d", k), got8[k], orig[k]);

    // BYPASS and the reserved mode code
    for (int k = 0; k < 8; k++) begin orig[k] = rnd_hv(); lv8[k] = orig[k]; exp8[k] = orig[k]; end
    run_batch8(16'd31, 2'b10, -1, 0, 1'b1, "bypass");
    for (int k = 0; k < 8; k++) lv8[k] = orig[k];
    run_batch8(16'd77, 2'b11, -1, 0, 1'b1, "mode11");

    // Partial last beat and table wrap (FEATURES=5)
    for (int k = 0; k < 5; k++) begin lv5[k] = oh(k); exp5[k] = oh(part_pos[k]); end
    exp5[5] = '0;
    start5 = 1'b1; base5 = 16'd255; mode5 = 2'b00; ordy5 = 1'b1;
    tick();
    start5 = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("part b%0d out_valid", b), 32'(ov5), 32'd1);
      chk($sformatf("part b%0d feat_idx", b), 32'(idx5), 32'(b * 2));
      chk($sformatf("part b%0d out_last", b), 32'(last5), (b == 2) ? 32'd1 : 32'd0);
      chk($sformatf("part b%0d lane_valid", b), 32'(lval5), (b == 2) ? 32'd1 : 32'd3);
      chk_hv($sformatf("part b%0d lane0", b), sh5[0], exp5[2*b]);
      chk_hv($sformatf("part b%0d lane1", b), sh5[1], exp5[2*b+1]);
      tick();
    end
    chk("part done", 32'(done5), 32'd1);
    chk("part idle valid", 32'(ov5), 32'd0);
    tick();

    // Ignored start during a batch, then reset mid-batch
    for (int k = 0; k < 8; k++) begin lv8[k] = oh(k); exp8[k] = oh(rotl_pos[k]); end
    start8 = 1'b1; base8 = 16'd248; mode8 = 2'b00; ordy8 = 1'b1;
    tick();
    start8 = 1'b0;
    check_beat8("mid", 0, 1'b1);
    tick();
    check_beat8("mid", 1, 1'b1);
    start8 = 1'b1; base8 = 16'd7; mode8 = 2'b10;
    tick();
    start8 = 1'b0; base8 = 16'd0; mode8 = 2'b00;
    check_beat8("mid ignored", 2, 1'b1);
    chk("mid busy", 32'(in_ready8), 32'd0);
    chk("mid state", 32'(st8), 32'(S_BIND));
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("mrst state", 32'(st8), 32'(S_IDLE));
    chk("mrst out_valid", 32'(ov8), 32'd0);
    chk("mrst done", 32'(done8), 32'd0);
    chk("mrst in_ready", 32'(in_ready8), 32'd1);
    chk("mrst out_last", 32'(last8), 32'd0);
    chk_hv("mrst lane0", sh8[0], '0);
    tick();
    chk("mrst no done", 32'(done8), 32'd0);
    chk("mrst still idle", 32'(ov8), 32'd0);

    // Clean batch after the reset
    for (int k = 0; k < 8; k++) begin lv8[k] = oh(k); exp8[k] = oh(rotl_pos[k]); end
    run_batch8(16'd248, 2'b00, -1, 0, 1'b1, "post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
